// File: rtl/speech_sig_pkg.sv
// Shared constants and types for the speech front-end: frame geometry,
// Q0.16 rounding constant and the frame sequencer state encoding.
package speech_sig_pkg;

  localparam int FRAME_LEN = 512;
  localparam int ADDR_W    = 9;
  localparam int ROUND_Q16 = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/win_out_fifo.sv
// Three-entry FIFO of {data, last}; head is visible combinationally, one-cycle push-to-head latency.
// Producer must respect occ (credit); a push into a full FIFO is dropped unless a pop frees the slot.
module win_out_fifo #(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    occ
);
  import speech_sig_pkg::*;

  logic [DW-1:0] mem [3];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd3) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/hamming_frame_sequencer.sv
// Streams one frame through the Hamming ROM: read at cycle 1 after start, first result valid at cycle 3.
// Reads are credit-gated on FIFO occupancy only, so win_ready stalls never drop or repeat a sample.
module hamming_frame_sequencer #(
  parameter int FRAME_LEN = speech_sig_pkg::FRAME_LEN,
  parameter int ADDR_W    = speech_sig_pkg::ADDR_W,
  parameter int SAMPLE_W  = 16,
  parameter int COEF_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  output logic                smp_rd,
  output logic [ADDR_W-1:0]   smp_addr,
  input  logic [SAMPLE_W-1:0] smp_data,
  input  logic [COEF_W-1:0]   coef,
  output logic [SAMPLE_W-1:0] win_out,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                win_last,
  output logic                busy,
  output logic                frame_done
);
  import speech_sig_pkg::*;

  localparam int PROD_W = SAMPLE_W + COEF_W + 1;
  localparam int ENT_W  = SAMPLE_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  seq_state_t               state;
  seq_state_t               state_nxt;
  logic [ADDR_W-1:0]        idx;
  logic                     s1_valid;
  logic                     s1_last;
  logic [1:0]               occ;
  logic                     issue;
  logic                     pop;
  logic                     last_pop;
  logic [ENT_W-1:0]         head;
  logic                     head_last;
  logic [SAMPLE_W-1:0]      win_res;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      s1_valid   <= issue;
      s1_last    <= issue && (idx == LAST_IDX);
      frame_done <= last_pop;
      if ((state == IDLE) && frame_start) idx <= '0;
      else if (issue)                     idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start)                  state_nxt = RUN;
      RUN:     if (issue && (idx == LAST_IDX))   state_nxt = DRAIN;
      DRAIN:   if (last_pop)                     state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Credit counts results already buffered plus the one still in stage 1.
  always_comb begin
    issue    = (state == RUN) && ((3'(occ) + 3'(s1_valid)) < 3'd3);
    smp_rd   = issue;
    smp_addr = idx;
    busy     = (state != IDLE);
  end

  assign prod    = PROD_W'($signed(smp_data)) * PROD_W'($signed({1'b0, coef}));
  assign rnd     = prod + PROD_W'(ROUND_Q16);
  assign win_res = SAMPLE_W'(rnd >>> COEF_W);

  win_out_fifo #(.DW(ENT_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s1_valid),
    .push_dat ({win_res, s1_last}),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  assign win_valid = (occ != 2'd0);
  assign head_last = head[0];
  assign win_out   = head[ENT_W-1:1];
  assign win_last  = win_valid && head_last;
  assign pop       = win_valid && win_ready;
  assign last_pop  = (state == DRAIN) && pop && head_last;

endmodule

// File: doc/hamming_frame_sequencer.md
# hamming_frame_sequencer

Sequences one 512-sample analysis frame through the Hamming coefficient ROM (`hamming_window_array`) and streams windowed samples to the FFT loader. It sits between the frame sample buffer and the FFT input stage. On a start pulse it reads the buffer and the ROM in lockstep, multiplies each sample by its coefficient, and emits results over a valid/ready handshake. It handles downstream backpressure without losing or duplicating samples.

## Interface
- `FRAME_LEN`, 512: samples per frame; fixed by ROM depth.
- `ADDR_W`, 9: sample and ROM address width.
- `SAMPLE_W`, 16: signed sample and output width.
- `COEF_W`, 16: unsigned Q0.16 coefficient width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse; accepted only in IDLE.
- `smp_rd`  out  1  sample buffer read strobe.
- `smp_addr`  out  ADDR_W  sample buffer address; also drives ROM `mul_addr`.
- `smp_data`  in  SAMPLE_W  signed sample, valid the cycle after `smp_rd`.
- `coef`  in  COEF_W  ROM `mul_out`, valid the cycle after the address.
- `win_out`  out  SAMPLE_W  signed windowed sample.
- `win_valid`  out  1  `win_out` is valid.
- `win_ready`  in  1  downstream accepts.
- `win_last`  out  1  marks sample index 511 while `win_valid` is high.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when the last sample is accepted.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `frame_start` clears the index counter and moves the block to RUN.
  - `busy` rises on the next edge.
- **RUN:**
  - Issue condition: `smp_rd` = 1 when `occ + s1_valid < 3`. `occ` is the output FIFO occupancy (0..3). `s1_valid` means a read was issued in the previous cycle.
  - `smp_addr` = index; the index increments on every issue.
  - After issuing index 511, move to DRAIN.
- **Stage 1 (cycle after issue):**
  - Product = signed `smp_data` × {1'b0, `coef`}, 33 bits signed.
  - Result = (product + 2^15) >>> 16, truncated to 16 bits.
  - No saturation is needed: the coefficient is < 1.0.
  - The result is pushed into the 3-entry output FIFO together with its last flag (index == 511).
- **FIFO:**
  - `win_valid` = (`occ` != 0); the head drives `win_out` and `win_last`.
  - Pop when `win_valid` & `win_ready`. Push and pop may happen in the same cycle.
  - The credit rule guarantees the FIFO never overflows. There is no combinational path from `win_ready` to `smp_rd`.
- **DRAIN:**
  - No further reads.
  - Popping the last-flagged entry pulses `frame_done`, drops `busy` and returns to IDLE.
- **Boundary cases:**
  - `frame_start` in RUN or DRAIN is ignored.
  - `win_ready` held low: at most 3 results are buffered, and `smp_rd` stalls at `smp_addr` ≤ 2.
  - Reset mid-frame clears the FSM, counter, FIFO and `s1_valid`. No `frame_done` is produced.
- **Reset values:** `smp_rd`, `smp_addr`, `win_out`, `win_valid`, `win_last`, `busy` and `frame_done` are all 0; state is IDLE.

## Timing
- **Startup:** `frame_start` at cycle 0 gives the first `smp_rd` at cycle 1 (addr 0) and the first `win_valid` at cycle 3.
- **Steady state:** with `win_ready` held high, one sample per cycle, giving a frame in 512 + 3 cycles to `frame_done`.
- **Ordering:** `frame_done` is asserted in the cycle after the last pop edge. A new `frame_start` is accepted from that cycle onward.
- **Stall recovery:** read issue resumes the cycle after a pop frees credit.

## Structure
- **Shared package** (`speech_sig_pkg`):
  - `FRAME_LEN` and `ADDR_W`.
  - The Q0.16 rounding constant (2^15).
  - The state enum {IDLE, RUN, DRAIN}.
- **Sub-module:** `win_out_fifo`, a 3-entry FIFO carrying {data, last}, with occupancy count, push and pop.
- **ROM:** `hamming_window_array` is instantiated by the parent, not inside this block.

## Test plan
- **Full-rate frame:** buffer filled with 16000, `win_ready` held 1, `frame_start` pulsed.
  - Output 0 = 1227 (16000×5027/65536 rounded); output 255 = 16000; output 511 = 1227.
  - Exactly 512 valids, `win_last` only on the 512th, `frame_done` at cycle 515.
- **Negative and full-scale samples:**
  - Sample −32768 at index 255 gives −32767.
  - Sample 32767 at index 0 gives 2513.
- **Backpressure:** `win_ready` held 0 for 20 cycles after start.
  - `occ` peaks at 3, reads stop at addr 2.
  - After release, the output order is intact and the count is exactly 512.
- **Random `win_ready` (50%):**
  - Output sequence equals the reference model.
  - No drops or duplicates; `smp_addr` strictly increments.
- **`frame_start` while busy:**
  - Pulses at cycles 10 and 400 are ignored; single `frame_done`.
  - A restart immediately after `frame_done` begins a new frame at addr 0.
- **Reset mid-frame:** `rst` at sample 200.
  - All outputs return to 0 and the state returns to IDLE; no `frame_done`.
  - A following frame is fully correct.
